// File: rtl/unigate_slot_mux.sv
// unigate_slot_mux: Wishbone-controlled pad multiplexer that lets several
// user projects share the caravel IO pads. A slot switch always passes
// through a tristate/reset drain period, so two slots never drive the pads
// in the same cycle and at most one slot is out of reset at any time.
module unigate_slot_mux #(
  parameter int          NUM_SLOTS  = 4,
  parameter int          IO_PADS    = 38,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          SETTLE_RST = 16
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_n,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_we_i,
  input  logic [3:0]                     wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [31:0]                    wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic [31:0]                    wbs_dat_o,
  output logic [IO_PADS-1:0]             io_out,
  output logic [IO_PADS-1:0]             io_oeb,
  input  logic [NUM_SLOTS*IO_PADS-1:0]   slot_io_out,
  input  logic [NUM_SLOTS*IO_PADS-1:0]   slot_io_oeb,
  input  logic [NUM_SLOTS*3-1:0]         slot_irq,
  output logic [NUM_SLOTS-1:0]           slot_rst_n,
  output logic [2:0]                     user_irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ACTIVE  = 2'd3
  } state_t;

  localparam logic [8:0] LP_NSLOTS     = 9'(NUM_SLOTS);
  localparam logic [7:0] LP_SETTLE_RST = 8'(SETTLE_RST);

  // Wishbone side
  logic        r_ack;
  logic [31:0] r_dat;
  logic [7:0]  r_ctrl_slot;
  logic        r_ctrl_en;
  logic        r_ctrl_go;     // pulses in the ack cycle of a valid CTRL write
  logic [2:0]  r_irq_mask;
  logic [7:0]  r_settle;
  logic        r_err;

  // Switch FSM side
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_target;      // slot requested when the current drain began
  logic        r_drain_en;    // enable value when the current drain began
  logic [7:0]  r_active;
  logic [IO_PADS-1:0]   r_io_out;
  logic [IO_PADS-1:0]   r_io_oeb;
  logic [NUM_SLOTS-1:0] r_slot_rst_n;
  logic [2:0]           r_user_irq;

  logic        w_hit;
  logic        w_req;
  logic        w_wr;
  logic [1:0]  w_off;
  logic [7:0]  w_ctrl_slot_new;
  logic        w_ctrl_en_new;
  logic        w_ctrl_valid;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic [7:0]  w_settle_ld;
  state_t      w_state_nxt;
  logic        w_drain_ld;
  logic        w_pad_live;
  logic [NUM_SLOTS-1:0] w_oh_active;
  logic [NUM_SLOTS-1:0] w_oh_target;
  logic [IO_PADS-1:0]   w_sel_out;
  logic [IO_PADS-1:0]   w_sel_oeb;
  logic [2:0]           w_sel_irq;
  logic                 w_unused;

  assign w_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_req  = wbs_cyc_i & wbs_stb_i & ~r_ack & w_hit;
  assign w_wr   = w_req & wbs_we_i;
  assign w_off  = wbs_adr_i[3:2];

  // Byte-lane merge of a CTRL write: slot in byte 0, enable in byte 1.
  assign w_ctrl_slot_new = wbs_sel_i[0] ? wbs_dat_i[7:0] : r_ctrl_slot;
  assign w_ctrl_en_new   = wbs_sel_i[1] ? wbs_dat_i[8]   : r_ctrl_en;
  assign w_ctrl_valid    = ({1'b0, w_ctrl_slot_new} < LP_NSLOTS);

  assign w_status = {21'h0, r_err, (r_state == ST_ACTIVE),
                     ((r_state == ST_DRAIN) || (r_state == ST_RELEASE)), r_active};
  assign w_settle_ld = (r_settle == 8'd0) ? 8'd1 : r_settle;
  assign w_unused    = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_sel_i[3:2]};

  // Register read mux.
  always_comb begin
    w_rdata = 32'h0;
    case (w_off)
      2'd0:    w_rdata = {23'h0, r_ctrl_en, r_ctrl_slot};
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {29'h0, r_irq_mask};
      2'd3:    w_rdata = {24'h0, r_settle};
      default: w_rdata = 32'h0;
    endcase
  end

  // Slot decode and selection of the active slot's buses (AND-OR mux).
  always_comb begin
    w_oh_active = '0;
    w_oh_target = '0;
    w_sel_out   = '0;
    w_sel_oeb   = '0;
    w_sel_irq   = 3'b000;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_oh_active[k] = (r_active == 8'(k));
      w_oh_target[k] = (r_target == 8'(k));
      w_sel_out = w_sel_out | (slot_io_out[k*IO_PADS +: IO_PADS] & {IO_PADS{w_oh_active[k]}});
      w_sel_oeb = w_sel_oeb | (slot_io_oeb[k*IO_PADS +: IO_PADS] & {IO_PADS{w_oh_active[k]}});
      w_sel_irq = w_sel_irq | (slot_irq[k*3 +: 3] & {3{w_oh_active[k]}});
    end
  end

  // Next-state decision of the switch sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_ctrl_go && r_ctrl_en) w_state_nxt = ST_DRAIN;
        else                        w_state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (r_cnt > 8'd1)                 w_state_nxt = ST_DRAIN;
        else if (r_ctrl_en && r_drain_en) w_state_nxt = ST_RELEASE;
        else if (r_ctrl_en)               w_state_nxt = ST_DRAIN;   // re-enabled while disabling
        else                              w_state_nxt = ST_IDLE;
      end
      ST_RELEASE: begin
        if (r_ctrl_en && (r_ctrl_slot == r_active)) w_state_nxt = ST_ACTIVE;
        else                                        w_state_nxt = ST_DRAIN;
      end
      ST_ACTIVE: begin
        if (r_ctrl_go && (!r_ctrl_en || (r_ctrl_slot != r_active))) w_state_nxt = ST_DRAIN;
        else                                                        w_state_nxt = ST_ACTIVE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Any entry into DRAIN (including a restart from DRAIN) reloads the settle counter.
  assign w_drain_ld = (w_state_nxt == ST_DRAIN) &&
                      ((r_state != ST_DRAIN) || (r_cnt <= 8'd1));
  // Pads follow a slot only while ACTIVE is both the current and the next state.
  assign w_pad_live = (r_state == ST_ACTIVE) && (w_state_nxt == ST_ACTIVE);

  // Wishbone handshake: single-cycle ack with registered read data.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack <= 1'b0;
      r_dat <= 32'h0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_rdata : 32'h0;
    end
  end

  // Control/status register writes; invalid slot requests only raise err.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ctrl_slot <= 8'h00;
      r_ctrl_en   <= 1'b0;
      r_ctrl_go   <= 1'b0;
      r_irq_mask  <= 3'b111;
      r_settle    <= LP_SETTLE_RST;
      r_err       <= 1'b0;
    end else begin
      r_ctrl_go <= w_wr && (w_off == 2'd0) && w_ctrl_valid;
      if (w_wr && (w_off == 2'd0)) begin
        if (w_ctrl_valid) begin
          r_ctrl_slot <= w_ctrl_slot_new;
          r_ctrl_en   <= w_ctrl_en_new;
          r_err       <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_wr && (w_off == 2'd2) && wbs_sel_i[0]) r_irq_mask <= wbs_dat_i[2:0];
      if (w_wr && (w_off == 2'd3) && wbs_sel_i[0]) r_settle   <= wbs_dat_i[7:0];
    end
  end

  // Switch sequencer state plus its registered pad, reset and irq outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'h00;
      r_target     <= 8'h00;
      r_drain_en   <= 1'b0;
      r_active     <= 8'h00;
      r_io_out     <= '0;
      r_io_oeb     <= '1;
      r_slot_rst_n <= '0;
      r_user_irq   <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      if (w_drain_ld) begin
        r_cnt      <= w_settle_ld;
        r_target   <= r_ctrl_slot;
        r_drain_en <= r_ctrl_en;
      end else if (r_state == ST_DRAIN) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_state_nxt == ST_RELEASE) r_active <= r_target;
      if (w_state_nxt == ST_RELEASE)     r_slot_rst_n <= w_oh_target;
      else if (w_state_nxt == ST_ACTIVE) r_slot_rst_n <= w_oh_active;
      else                               r_slot_rst_n <= '0;
      r_io_out   <= w_pad_live ? w_sel_out : '0;
      r_io_oeb   <= w_pad_live ? w_sel_oeb : '1;
      r_user_irq <= w_pad_live ? (w_sel_irq & r_irq_mask) : 3'b000;
    end
  end

  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = r_dat;
  assign io_out     = r_io_out;
  assign io_oeb     = r_io_oeb;
  assign slot_rst_n = r_slot_rst_n;
  assign user_irq   = r_user_irq;

endmodule
